// File: rtl/neuralnet_seq_ctrl.sv
// neuralnet_seq_ctrl: command-driven load/classify sequencer for the neural-net datapath
//   optional stall timeout: NN_SEQ_TIMEOUT_EN
//   cmd_valid/cmd_ready/cmd_op     host command (0 learn, 1 classify)
//   wdata_valid/wdata_ready/wdata  weight beats, [31:0] to *DATA1, [63:32] to *DATA2
//   pix_valid/pix_ready/pix        4-pixel frame
//   pixels, learn, classify        datapath frame and strobes
//   KIDATA*/W1IDATA*/W2IDATA*      datapath weight buses
//   nn_result                      datapath result
//   res_valid/res_ready/res_data   result channel
//   busy, err                      status, timeout pulse
module neuralnet_seq_ctrl #(
    parameter int KI_BEATS     = 4,
    parameter int W1_BEATS     = 8,
    parameter int W2_BEATS     = 8,
    parameter int CLASSIFY_LAT = 6,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [63:0] wdata,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix,
    output logic [31:0] pixels,
    output logic        learn,
    output logic        classify,
    output logic [31:0] KIDATA1,
    output logic [31:0] KIDATA2,
    output logic [31:0] W1IDATA1,
    output logic [31:0] W1IDATA2,
    output logic [31:0] W2IDATA1,
    output logic [31:0] W2IDATA2,
    input  logic [7:0]  nn_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, LOAD_KI, LOAD_W1, LOAD_W2, PIX, WAIT, RESULT} state_t;
    localparam logic [7:0] KI_LAST = 8'(KI_BEATS - 1);
    localparam logic [7:0] W1_LAST = 8'(W1_BEATS - 1);
    localparam logic [7:0] W2_LAST = 8'(W2_BEATS - 1);
    localparam logic [7:0] LAT     = 8'(CLASSIFY_LAT);
    state_t state, state_n;
    logic [7:0] beat, lat;
    logic wacc, pacc, last, tmo;
    assign cmd_ready   = state == IDLE;
    assign wdata_ready = state == LOAD_KI || state == LOAD_W1 || state == LOAD_W2;
    assign pix_ready   = state == PIX;
    assign wacc        = wdata_valid & wdata_ready;
    assign pacc        = pix_valid & pix_ready;
    assign last        = beat == (state == LOAD_KI ? KI_LAST : state == LOAD_W1 ? W1_LAST : W2_LAST);
`ifdef NN_SEQ_TIMEOUT_EN
    logic [15:0] stall;
    // timeout fires on the TIMEOUT-th consecutive cycle without progress
    assign tmo = (wdata_ready | pix_ready) & ~wacc & ~pacc & (stall == 16'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            stall <= (wacc | pacc | ~(wdata_ready | pix_ready)) ? '0 : stall + 16'd1;
            err   <= tmo;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = cmd_op ? PIX : LOAD_KI;
            LOAD_KI: if (wacc && last) state_n = LOAD_W1;
            LOAD_W1: if (wacc && last) state_n = LOAD_W2;
            LOAD_W2: if (wacc && last) state_n = IDLE;
            PIX:     if (pacc) state_n = WAIT;
            WAIT:    if (lat == 8'd0) state_n = RESULT;
            RESULT:  if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= '0;
            lat       <= '0;
            learn     <= 1'b0;
            classify  <= 1'b0;
            busy      <= 1'b0;
            pixels    <= '0;
            KIDATA1   <= '0;
            KIDATA2   <= '0;
            W1IDATA1  <= '0;
            W1IDATA2  <= '0;
            W2IDATA1  <= '0;
            W2IDATA2  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            learn    <= wacc;
            classify <= pacc;
            busy     <= state_n != IDLE;
            beat     <= (state_n != state) ? 8'd0 : beat + {7'd0, wacc};
            if (wacc && state == LOAD_KI) {KIDATA2, KIDATA1} <= wdata;
            if (wacc && state == LOAD_W1) {W1IDATA2, W1IDATA1} <= wdata;
            if (wacc && state == LOAD_W2) {W2IDATA2, W2IDATA1} <= wdata;
            if (pacc) begin
                pixels <= pix;
                lat    <= LAT;
            end else if (state == WAIT && lat != 8'd0) begin
                lat <= lat - 8'd1;
            end
            if (state == WAIT && lat == 8'd0) begin
                res_data  <= nn_result;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neuralnet_seq_ctrl.sv
// tb_neuralnet_seq_ctrl: directed self-checking bench for neuralnet_seq_ctrl
module tb_neuralnet_seq_ctrl;
    localparam int LAT = 6;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [63:0] wdata = '0;
    logic        pix_valid = 1'b0, pix_ready;
    logic [31:0] pix = '0, pixels;
    logic        learn, classify;
    logic [31:0] KIDATA1, KIDATA2, W1IDATA1, W1IDATA2, W2IDATA1, W2IDATA2;
    logic [7:0]  nn_result = 8'h5A, res_data;
    logic        res_valid, res_ready = 1'b0, busy, err;
    int checks = 0, errors = 0;
    int nlearn = 0, ncls = 0, nerr = 0;
    int l0, c0;

    neuralnet_seq_ctrl #(.CLASSIFY_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix(pix),
        .pixels(pixels), .learn(learn), .classify(classify),
        .KIDATA1(KIDATA1), .KIDATA2(KIDATA2), .W1IDATA1(W1IDATA1), .W1IDATA2(W1IDATA2),
        .W2IDATA1(W2IDATA1), .W2IDATA2(W2IDATA2),
        .nn_result(nn_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (learn) nlearn <= nlearn + 1;
        if (classify) ncls <= ncls + 1;
        if (err) nerr <= nerr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bw(input int p, input int i);
        logic [7:0] b;
        b = 8'(p * 16 + i);
        return {24'hAA0000, b, 24'h0, b};
    endfunction

    task automatic check_weights(input string tag);
        chk({tag, "_ki1"}, KIDATA1, 64'h13);
        chk({tag, "_ki2"}, KIDATA2, 64'hAA000013);
        chk({tag, "_w11"}, W1IDATA1, 64'h27);
        chk({tag, "_w12"}, W1IDATA2, 64'hAA000027);
        chk({tag, "_w21"}, W2IDATA1, 64'h37);
        chk({tag, "_w22"}, W2IDATA2, 64'hAA000037);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_learn", learn, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_ki1", KIDATA1, 0);
        chk("rst_pixels", pixels, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        // back-to-back learn
        cmd_valid = 1'b1; cmd_op = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        l0 = nlearn;
        chk("learn_busy", busy, 1);
        for (int p = 1; p <= 3; p++)
            for (int i = 0; i < (p == 1 ? 4 : 8); i++) begin
                wdata = bw(p, i); wdata_valid = 1'b1;
                chk("learn_wready", wdata_ready, 1);
                @(negedge clk);
            end
        wdata_valid = 1'b0;
        chk("learn_done_cmd_ready", cmd_ready, 1);
        chk("learn_done_busy", busy, 0);
        chk("learn_last_pulse", learn, 1);
        @(negedge clk);
        chk("learn_count", 64'(nlearn - l0), 20);
        check_weights("b2b");
        // classify
        c0 = ncls;
        cmd_valid = 1'b1; cmd_op = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pix_ready", pix_ready, 1);
        pix = 32'h04030201; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("cls_strobe", classify, 1);
        chk("cls_pixels", pixels, 64'h04030201);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("cls_wait_no_valid", res_valid, 0);
        end
        @(negedge clk);
        chk("cls_res_valid", res_valid, 1);
        chk("cls_res_data", res_data, 64'h5A);
        chk("cls_count", 64'(ncls - c0), 1);
        // held result, stalled command
        nn_result = 8'h11;
        cmd_valid = 1'b1; cmd_op = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data", res_data, 64'h5A);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_res_valid", res_valid, 0);
        chk("stalled_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stalled_cmd_taken", wdata_ready, 1);
        // reset mid W1
        for (int i = 0; i < 4 + 5; i++) begin
            wdata = i < 4 ? bw(1, i) : bw(2, i - 4); wdata_valid = 1'b1;
            @(negedge clk);
        end
        chk("pre_rst_w1", W1IDATA1, 64'h24);
        wdata_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wready", wdata_ready, 0);
        chk("mid_rst_learn", learn, 0);
        chk("mid_rst_ki1", KIDATA1, 0);
        chk("mid_rst_w11", W1IDATA1, 0);
        chk("mid_rst_pixels", pixels, 0);
        chk("mid_rst_res_data", res_data, 0);
        rst = 1'b0;
        // gapped learn, stray pix_valid during gaps
        cmd_valid = 1'b1; cmd_op = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("gap_wready", wdata_ready, 1);
        chk("gap_pix_ready", pix_ready, 0);
        l0 = nlearn;
        for (int p = 1; p <= 3; p++)
            for (int i = 0; i < (p == 1 ? 4 : 8); i++) begin
                wdata = bw(p, i); wdata_valid = 1'b1; pix_valid = 1'b0;
                @(negedge clk);
                wdata_valid = 1'b0; wdata = '1; pix_valid = 1'b1; pix = 32'hDEADBEEF;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        pix_valid = 1'b0;
        chk("gap_learn_count", 64'(nlearn - l0), 20);
        check_weights("gap");
        chk("gap_pixels", pixels, 0);
        // stray beat while idle
        wdata_valid = 1'b1; wdata = '1;
        repeat (2) @(negedge clk);
        wdata_valid = 1'b0;
        chk("idle_beat_learn", 64'(nlearn - l0), 20);
        check_weights("idle");
`ifdef NN_SEQ_TIMEOUT_EN
        c0 = ncls;
        cmd_valid = 1'b1; cmd_op = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (254) @(negedge clk);
        chk("tmo_not_yet", err, 0);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        @(negedge clk);
        chk("tmo_single", 64'(nerr), 1);
        chk("tmo_no_cls", 64'(ncls - c0), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
